gx4000_asic_unlock: RTL and testbench
=====================================

GX4000_ASIC_UNLOCK -- requirements
Module: gx4000_asic_unlock

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named clk_sys and reset.
REQ-002 Parameter KEY_LEN, default 15, SHALL set the key bytes compared after the 0x00 sync byte (range 1..15).
REQ-003 Parameter PORT_HI, default 8'hBC, SHALL set the io_addr[15:8] value that qualifies a write.
REQ-004 Parameter STICKY, default 0; when 1, a completed unlock SHALL be immune to relock until reset.
REQ-005 Parameter CNT_W, default 8, SHALL set the width of attempt_count.
REQ-006 Ports (name, direction, width, meaning):
- clk_sys, in, 1: system clock.
- reset, in, 1: async active-high reset.
- plus_mode, in, 1: Plus features enabled.
- io_addr, in, 16: CPU I/O address.
- io_data, in, 8: CPU write data.
- io_wr, in, 1: single-cycle qualified I/O write strobe.
- unlocked, out, 1: ASIC register page enabled.
- unlock_pulse, out, 1: one-cycle pulse on the lock-to-unlock transition.
- lock_pulse, out, 1: one-cycle pulse on the unlock-to-lock transition.
- seq_pos, out, 4: current key index, 0 when not in MATCH.
- attempt_count, out, CNT_W: count of completed key sequences.

Function
REQ-007 A write is accepted when io_wr=1, plus_mode=1 and io_addr[15:8]=PORT_HI; all other cycles SHALL leave state unchanged.
REQ-008 FSM states are IDLE, SYNC, MATCH and FINAL; every transition occurs on an accepted write only.
REQ-009 IDLE: a nonzero byte goes to SYNC; 0x00 stays in IDLE.
REQ-010 SYNC: 0x00 goes to MATCH with idx=0; a nonzero byte stays in SYNC.
REQ-011 MATCH: if data equals KEY[idx] and idx<KEY_LEN-1, then idx increments; if idx=KEY_LEN-1, go to FINAL.
REQ-012 MATCH mismatch: a nonzero byte goes to SYNC; 0x00 goes to MATCH with idx=0.
REQ-013 FINAL: 0xEE sets unlocked=1; any other byte sets unlocked=0, unless STICKY=1 and unlocked=1 already.
REQ-014 After FINAL, the next state is SYNC for nonzero data and MATCH idx=0 for 0x00.
REQ-015 FINAL SHALL increment attempt_count, saturating at 2^CNT_W-1 (no wrap).
REQ-016 unlock_pulse and lock_pulse SHALL fire only when unlocked actually changes; a repeat unlock produces no pulse.
REQ-017 All outputs SHALL be registered, with latency of 1 clk_sys after the accepted write.
REQ-018 plus_mode=0 SHALL force IDLE and unlocked=0 on the next clock regardless of STICKY, pulsing lock_pulse if unlocked was 1.
REQ-019 If plus_mode falls in the same cycle as an accepted write, plus_mode takes priority and the write is ignored.
REQ-020 Writes with io_addr[7:0] of any value SHALL be treated identically.

Reset
REQ-021 Reset SHALL set the FSM to IDLE, idx=0, unlocked=0, both pulses=0, seq_pos=0 and attempt_count=0.
REQ-022 Reset asserted mid-sequence SHALL discard progress; after release, a full sync+key+0xEE sequence is required.

Structure
REQ-023 Package gx4000_pkg SHALL hold the FSM enum type, KEY[0:14] = FF 77 B3 51 A8 D4 62 39 9C 46 2B 15 8A CD (plus 0x00 padding to 15 entries), and the UNLOCK_BYTE=8'hEE constant.
REQ-024 KEY_LEN SHALL index only the first KEY_LEN entries of the package key.
REQ-025 The block SHALL be a single module; the saturating counter SHALL be the sub-module gx4000_sat_counter.

Verification
REQ-026 Write BC00 with 01, 00, then KEY[0..13], then EE -> unlocked=1 one clock later, unlock_pulse=1 for exactly one cycle, attempt_count=1.
REQ-027 From the unlocked state, repeat the sequence ending in 0x55 -> unlocked=0, lock_pulse=1; with STICKY=1 -> unlocked stays 1, no pulse, attempt_count=2.
REQ-028 Send 01, 00, FF, 77, 00 (mismatch zero), then KEY[0..13], EE -> unlocked=1 (the restart path works).
REQ-029 Writes to 7F00 interleaved within the sequence -> ignored, unlock still succeeds; a reset pulse after KEY[6] -> EE yields no unlock.
REQ-030 With CNT_W=2, run 5 complete sequences -> attempt_count=3.
REQ-031 While unlocked, drop plus_mode -> unlocked=0 next clock and lock_pulse=1; an accepted write in the same cycle has no effect.

Source files
------------

// File: rtl/gx4000_pkg.sv
// Shared types and constants for the GX4000 Plus ASIC unlock sequence detector.
// Holds the FSM state type, the 15-entry unlock key and the final unlock byte.
package gx4000_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SYNC  = 2'd1,
      ST_MATCH = 2'd2,
      ST_FINAL = 2'd3
   } unlock_state_e;

   localparam int KEY_MAX = 15;

   // Key bytes after the 0x00 sync byte; the last entry is padding
   localparam logic [7:0] KEY [0:KEY_MAX-1] = '{
      8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62, 8'h39,
      8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'h00
   };

   localparam logic [7:0] UNLOCK_BYTE = 8'hEE;

endpackage

// File: rtl/gx4000_sat_counter.sv
// Saturating up-counter used to count completed unlock key sequences.
// Holds at all-ones instead of wrapping.
module gx4000_sat_counter #(
   parameter int W = 8
) (
   input  logic         clk_sys,
   input  logic         reset,
   input  logic         inc,
   output logic [W-1:0] count
);

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         count <= '0;
      end else if (inc && (count != '1)) begin
         count <= count + W'(1);
      end
   end

endmodule

// File: rtl/gx4000_asic_unlock.sv
// Watches CPU writes to the Plus ASIC port and enables the ASIC register page once the
// sync byte, the key bytes and the final unlock byte arrive in order.
module gx4000_asic_unlock
   import gx4000_pkg::*;
#(
   parameter int         KEY_LEN = 15,
   parameter logic [7:0] PORT_HI = 8'hBC,
   parameter bit         STICKY  = 1'b0,
   parameter int         CNT_W   = 8
) (
   input  logic             clk_sys,
   input  logic             reset,
   input  logic             plus_mode,
   input  logic [15:0]      io_addr,
   input  logic [7:0]       io_data,
   input  logic             io_wr,
   output logic             unlocked,
   output logic             unlock_pulse,
   output logic             lock_pulse,
   output logic [3:0]       seq_pos,
   output logic [CNT_W-1:0] attempt_count
);

   localparam logic [3:0] LAST_IDX = 4'(KEY_LEN - 1);

   unlock_state_e state, state_nxt;
   logic [3:0]    idx, idx_nxt;
   logic          unlocked_nxt;
   logic          accept;
   logic          zero_byte;
   logic          key_hit;
   logic          final_write;
   logic          unused_addr_lo;

   // The low address byte does not take part in port decoding
   assign unused_addr_lo = ^io_addr[7:0];

   assign accept      = io_wr && plus_mode && (io_addr[15:8] == PORT_HI);
   assign zero_byte   = (io_data == 8'h00);
   assign key_hit     = (io_data == KEY[idx]);
   assign final_write = accept && (state == ST_FINAL);

   always_comb begin
      // NOTE: every output of this block gets a default first, so no path can infer a latch.
      state_nxt    = state;
      idx_nxt      = idx;
      unlocked_nxt = unlocked;

      if (!plus_mode) begin
         state_nxt    = ST_IDLE;
         idx_nxt      = '0;
         unlocked_nxt = 1'b0;
      end else if (accept) begin
         unique case (state)
            ST_IDLE: begin
               if (!zero_byte) state_nxt = ST_SYNC;
            end
            ST_MATCH: begin
               if (key_hit) begin
                  if (idx == LAST_IDX) begin
                     state_nxt = ST_FINAL;
                     idx_nxt   = '0;
                  end else begin
                     idx_nxt = idx + 4'd1;
                  end
               end else begin
                  state_nxt = zero_byte ? ST_MATCH : ST_SYNC;
                  idx_nxt   = '0;
               end
            end
            ST_FINAL: begin
               unlocked_nxt = (io_data == UNLOCK_BYTE) || (STICKY && unlocked);
               state_nxt    = zero_byte ? ST_MATCH : ST_SYNC;
               idx_nxt      = '0;
            end
            // SYNC waits for a zero byte; a nonzero byte leaves it in SYNC
            default: begin
               state_nxt = zero_byte ? ST_MATCH : ST_SYNC;
               idx_nxt   = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk_sys or posedge reset) begin
      if (reset) begin
         state        <= ST_IDLE;
         idx          <= '0;
         unlocked     <= 1'b0;
         unlock_pulse <= 1'b0;
         lock_pulse   <= 1'b0;
         seq_pos      <= '0;
      end else begin
         state        <= state_nxt;
         idx          <= idx_nxt;
         unlocked     <= unlocked_nxt;
         unlock_pulse <= unlocked_nxt && !unlocked;
         lock_pulse   <= !unlocked_nxt && unlocked;
         seq_pos      <= (state_nxt == ST_MATCH) ? idx_nxt : 4'd0;
      end
   end

   gx4000_sat_counter #(
      .W(CNT_W)
   ) u_attempts (
      .clk_sys(clk_sys),
      .reset  (reset),
      .inc    (final_write),
      .count  (attempt_count)
   );

endmodule

// File: tb/tb_gx4000_asic_unlock.sv
// Self-checking bench: two unlock detectors (plain 8-bit counter, sticky 2-bit counter)
// share one write stream and are compared every cycle against a progress-count model.
module tb_gx4000_asic_unlock;

   localparam int K = 14;

   logic        clk_sys = 1'b0;
   logic        reset;
   logic        plus_mode;
   logic [15:0] io_addr;
   logic [7:0]  io_data;
   logic        io_wr;

   logic       unl0, up0, lp0;
   logic [3:0] pos0;
   logic [7:0] cnt0;
   logic       unl1, up1, lp1;
   logic [3:0] pos1;
   logic [1:0] cnt1;

   int checks   = 0;
   int failures = 0;

   logic [7:0] key [0:13] = '{8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                              8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD};

   always #5 clk_sys = ~clk_sys;

   gx4000_asic_unlock #(.KEY_LEN(K), .PORT_HI(8'hBC), .STICKY(1'b0), .CNT_W(8)) u_dut (
      .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .io_addr(io_addr),
      .io_data(io_data), .io_wr(io_wr), .unlocked(unl0), .unlock_pulse(up0),
      .lock_pulse(lp0), .seq_pos(pos0), .attempt_count(cnt0));

   gx4000_asic_unlock #(.KEY_LEN(K), .PORT_HI(8'hBC), .STICKY(1'b1), .CNT_W(2)) u_sticky (
      .clk_sys(clk_sys), .reset(reset), .plus_mode(plus_mode), .io_addr(io_addr),
      .io_data(io_data), .io_wr(io_wr), .unlocked(unl1), .unlock_pulse(up1),
      .lock_pulse(lp1), .seq_pos(pos1), .attempt_count(cnt1));

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Model: prog = -2 idle, -1 hunting a zero, 0..K-1 key bytes matched, K awaiting verdict
   int m_prog [2];
   bit m_unl  [2];
   bit m_up   [2];
   bit m_lp   [2];
   int m_cnt  [2];
   bit m_sticky [2] = '{1'b0, 1'b1};
   int m_cmax   [2] = '{255, 3};

   always @(posedge clk_sys or posedge reset) begin
      for (int i = 0; i < 2; i++) begin
         if (reset) begin
            m_prog[i] = -2; m_unl[i] = 0; m_up[i] = 0; m_lp[i] = 0; m_cnt[i] = 0;
         end else begin
            bit nu;
            nu = m_unl[i];
            if (!plus_mode) begin
               m_prog[i] = -2;
               nu = 0;
            end else if (io_wr && io_addr[15:8] == 8'hBC) begin
               if (m_prog[i] == K) begin
                  if (m_cnt[i] < m_cmax[i]) m_cnt[i]++;
                  nu = (io_data == 8'hEE) || (m_sticky[i] && m_unl[i]);
                  m_prog[i] = (io_data == 8'h00) ? 0 : -1;
               end else if (m_prog[i] >= 0 && io_data == key[m_prog[i]]) begin
                  m_prog[i]++;
               end else if (m_prog[i] == -2) begin
                  m_prog[i] = (io_data == 8'h00) ? -2 : -1;
               end else begin
                  m_prog[i] = (io_data == 8'h00) ? 0 : -1;
               end
            end
            m_up[i]  = nu && !m_unl[i];
            m_lp[i]  = !nu && m_unl[i];
            m_unl[i] = nu;
         end
      end
   end

   function automatic int exp_pos(input int p);
      return (p >= 0 && p < K) ? p : 0;
   endfunction

   always @(negedge clk_sys) begin
      check("cyc.unlocked0", unl0, m_unl[0]);
      check("cyc.unlock_pulse0", up0, m_up[0]);
      check("cyc.lock_pulse0", lp0, m_lp[0]);
      check("cyc.seq_pos0", pos0, exp_pos(m_prog[0]));
      check("cyc.count0", cnt0, m_cnt[0]);
      check("cyc.unlocked1", unl1, m_unl[1]);
      check("cyc.unlock_pulse1", up1, m_up[1]);
      check("cyc.lock_pulse1", lp1, m_lp[1]);
      check("cyc.seq_pos1", pos1, exp_pos(m_prog[1]));
      check("cyc.count1", cnt1, m_cnt[1]);
   end

   task automatic step();
      @(posedge clk_sys);
      #1;
   endtask

   task automatic wr(input logic [15:0] a, input logic [7:0] d);
      io_addr = a; io_data = d; io_wr = 1'b1;
      step();
      io_wr = 1'b0;
   endtask

   task automatic send_key(input int lo, input int hi);
      for (int j = lo; j <= hi; j++) wr(16'hBC00, key[j]);
   endtask

   task automatic full_seq(input logic [7:0] last);
      wr(16'hBC00, 8'h01);
      wr(16'hBC00, 8'h00);
      send_key(0, K - 1);
      wr(16'hBC00, last);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      step();
      reset = 1'b0;
      step();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1);
   end

   initial begin
      plus_mode = 1'b1; io_addr = '0; io_data = '0; io_wr = 1'b0; reset = 1'b1;
      step(); step();
      reset = 1'b0;
      step();
      check("rst.unlocked", unl0, 0);
      check("rst.count", cnt0, 0);
      check("rst.seq_pos", pos0, 0);

      // Basic unlock with a seq_pos probe part way in
      wr(16'hBC00, 8'h01);
      wr(16'hBC00, 8'h00);
      send_key(0, 1);
      check("mid.seq_pos", pos0, 2);
      send_key(2, K - 1);
      wr(16'hBC00, 8'hEE);
      check("unlock.unlocked", unl0, 1);
      check("unlock.pulse", up0, 1);
      check("unlock.count", cnt0, 1);
      step();
      check("unlock.pulse_once", up0, 0);

      // Relock with a bad final byte; the sticky instance holds
      full_seq(8'h55);
      check("relock.unlocked0", unl0, 0);
      check("relock.lock_pulse0", lp0, 1);
      check("relock.count0", cnt0, 2);
      check("sticky.unlocked1", unl1, 1);
      check("sticky.lock_pulse1", lp1, 0);
      check("sticky.count1", cnt1, 2);

      // Repeat unlock on an already-unlocked block gives no pulse
      full_seq(8'hEE);
      check("repeat.unlock_pulse1", up1, 0);
      check("repeat.unlock_pulse0", up0, 1);
      check("repeat.count1_sat", cnt1, 3);

      // plus_mode drop beats a same-cycle write
      plus_mode = 1'b0; io_addr = 16'hBC00; io_data = 8'h01; io_wr = 1'b1;
      step();
      io_wr = 1'b0;
      check("plus.unlocked0", unl0, 0);
      check("plus.lock_pulse0", lp0, 1);
      check("plus.unlocked1", unl1, 0);
      check("plus.lock_pulse1", lp1, 1);
      check("plus.count0", cnt0, 3);
      plus_mode = 1'b1;
      step();

      // Restart path via a mismatching zero byte
      wr(16'hBC00, 8'h01);
      wr(16'hBC00, 8'h00);
      send_key(0, 1);
      wr(16'hBC00, 8'h00);
      send_key(0, K - 1);
      wr(16'hBC00, 8'hEE);
      check("restart.unlocked", unl0, 1);
      check("restart.count", cnt0, 4);

      // Foreign-port writes interleaved; low address byte varies
      do_reset();
      wr(16'hBC00, 8'h01);
      wr(16'h7F00, 8'h00);
      wr(16'hBC7E, 8'h00);
      for (int j = 0; j < K; j++) begin
         wr(16'hBC00 | 16'(j), key[j]);
         wr(16'h7F00, 8'h00);
      end
      wr(16'hBCFF, 8'hEE);
      check("interleave.unlocked", unl0, 1);
      check("interleave.count", cnt0, 1);

      // Reset mid-sequence discards progress
      do_reset();
      wr(16'hBC00, 8'h01);
      wr(16'hBC00, 8'h00);
      send_key(0, 6);
      do_reset();
      wr(16'hBC00, 8'hEE);
      send_key(7, K - 1);
      wr(16'hBC00, 8'hEE);
      check("midreset.unlocked", unl0, 0);
      check("midreset.count", cnt0, 0);

      // Saturation of the 2-bit counter
      do_reset();
      for (int n = 0; n < 5; n++) full_seq(8'hEE);
      check("sat.count1", cnt1, 3);
      check("sat.count0", cnt0, 5);

      step(); step();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
